// File: rtl/relax_osc_pkg.sv
// relax_osc_pkg: shared definitions for the relaxation-oscillator frequency meter.
//   - state_e      : measurement FSM states (IDLE, COUNT, LATCH)
//   - DEF_*        : default values for the NUM_CH, CNT_W and GATE_W parameters
//   - sel_width()  : width of the channel-select port, never below 1 bit
package relax_osc_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GATE_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relax_osc_edge_sync.sv
// relax_osc_edge_sync: brings one asynchronous oscillator output into the clk
// domain through a 2-flop synchroniser and emits a one-cycle pulse on each
// synchronised rising edge.
//   clk     : sole clock
//   rst     : synchronous active-high reset, clears all flops
//   osc_i   : asynchronous oscillator input
//   pulse_o : high for one cycle per rising edge (synced 1, previous synced 0)
module relax_osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], osc_i};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/relax_osc_meter.sv
// relax_osc_meter: counts rising edges of NUM_CH relaxation oscillators over a
// programmable window of gate_cycles clk cycles and latches the counts.
//   clk, rst    : clock and synchronous active-high reset
//   osc_in      : asynchronous oscillator outputs, one bit per channel
//   gate_cycles : window length, sampled when start is accepted
//   start       : one-cycle measurement request, ignored while busy
//   sel         : channel shown on count_out (out-of-range selects read 0)
//   busy        : window open (COUNT or LATCH)
//   done        : one-cycle pulse when new results are latched
//   count_out   : registered result of channel sel
//   ovf         : per-channel saturation flags, present only when the macro
//                 RELAX_OSC_METER_OVERFLOW_EN is defined
module relax_osc_meter
    import relax_osc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] osc_in,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count_out
`ifdef RELAX_OSC_METER_OVERFLOW_EN
    ,
    output logic [NUM_CH-1:0] ovf
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic              clear_cnt, count_en, latch_en;
    logic              done_q;
    logic [CNT_W-1:0]  count_out_q, count_out_d;
    logic [CNT_W-1:0]  res_all [NUM_CH];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            done_q  <= latch_en;
        end
    end

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        clear_cnt = 1'b0;
        count_en  = 1'b0;
        latch_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    gate_d    = gate_cycles;
                    clear_cnt = 1'b1;
                    // A zero-length window skips COUNT and latches the cleared counters.
                    state_d   = (gate_cycles == '0) ? LATCH : COUNT;
                end
            end
            COUNT: begin
                count_en = 1'b1;
                gate_d   = gate_q - GATE_W'(1);
                if (gate_q == GATE_W'(1)) state_d = LATCH;
            end
            LATCH: begin
                latch_en = 1'b1;
                state_d  = IDLE;
            end
            // The unused encoding falls back to IDLE so a glitch cannot wedge the FSM.
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == COUNT) || (state_q == LATCH);
    assign done = done_q;

    // ---------------- per-channel datapath ----------------
`ifdef RELAX_OSC_METER_OVERFLOW_EN
    logic [NUM_CH-1:0] ovf_all;
    assign ovf = ovf_all;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic             pulse;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] res_q;

        relax_osc_edge_sync u_sync (
            .clk     (clk),
            .rst     (rst),
            .osc_i   (osc_in[gi]),
            .pulse_o (pulse)
        );

        // Saturating edge counter: an edge arriving at full scale is dropped.
        always_ff @(posedge clk) begin
            if (rst || clear_cnt) begin
                cnt_q <= '0;
            end else if (count_en && pulse && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                res_q <= '0;
            end else if (latch_en) begin
                res_q <= cnt_q;
            end
        end

        assign res_all[gi] = res_q;

`ifdef RELAX_OSC_METER_OVERFLOW_EN
        // sat_q remembers that an edge was dropped in this window; ovf_q
        // publishes it alongside the results.
        logic sat_q;
        logic ovf_q;

        always_ff @(posedge clk) begin
            if (rst || clear_cnt) begin
                sat_q <= 1'b0;
            end else if (count_en && pulse && (cnt_q == CNT_MAX)) begin
                sat_q <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ovf_q <= 1'b0;
            end else if (latch_en) begin
                ovf_q <= sat_q;
            end
        end

        assign ovf_all[gi] = ovf_q;
`endif
    end

    // ---------------- result readout ----------------
    always_comb begin
        count_out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) count_out_d = res_all[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out_q <= '0;
        end else begin
            count_out_q <= count_out_d;
        end
    end

    assign count_out = count_out_q;

endmodule

// File: tb/tb_relax_osc_meter.sv
// Scoreboard bench for relax_osc_meter: expected per-channel counts are queued
// when a measurement is started and popped while sweeping sel after done.
// A second instance with CNT_W=4 exercises saturation.
`timescale 1ns/1ps
module tb_relax_osc_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  osc = 4'b0;
    logic [3:0]  osc_s = 4'b0;
    logic [19:0] gate = '0;
    logic [19:0] gate_s = '0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [2:0]  sel = '0;
    logic [2:0]  sel_s = '0;
    logic        busy, done, busy_s, done_s;
    logic [15:0] count_out;
    logic [3:0]  count_out_s;
`ifdef RELAX_OSC_METER_OVERFLOW_EN
    logic [3:0]  ovf, ovf_s;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    relax_osc_meter #(.NUM_CH(4), .CNT_W(16), .GATE_W(20), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .osc_in(osc), .gate_cycles(gate), .start(start),
        .sel(sel), .busy(busy), .done(done), .count_out(count_out)
`ifdef RELAX_OSC_METER_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    relax_osc_meter #(.NUM_CH(4), .CNT_W(4), .GATE_W(20), .SEL_W(3)) dut_sat (
        .clk(clk), .rst(rst), .osc_in(osc_s), .gate_cycles(gate_s), .start(start_s),
        .sel(sel_s), .busy(busy_s), .done(done_s), .count_out(count_out_s)
`ifdef RELAX_OSC_METER_OVERFLOW_EN
        , .ovf(ovf_s)
`endif
    );

    // Free-running oscillators, changed on the falling clk edge.
    // Main: ch0 period 10, ch1 period 25, ch2/ch3 idle. Saturation DUT: ch0 period 8.
    initial begin
        int per [4];
        int per_s [4];
        int ph [4];
        int ph_s [4];
        per = '{10, 25, 0, 0};
        per_s = '{8, 0, 0, 0};
        ph = '{0, 0, 0, 0};
        ph_s = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (per[c] == 0) osc[c] = 1'b0;
                else begin
                    ph[c] = (ph[c] + 1) % per[c];
                    osc[c] = (ph[c] < per[c] / 2);
                end
                if (per_s[c] == 0) osc_s[c] = 1'b0;
                else begin
                    ph_s[c] = (ph_s[c] + 1) % per_s[c];
                    osc_s[c] = (ph_s[c] < per_s[c] / 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start_s = 1'b1; gate = 20'd5; gate_s = 20'd5;
        tick(); tick();
        rst = 1'b0; start = 1'b0; start_s = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        tick();
        checks++; if ((busy !== 1'b0) || (busy_s !== 1'b0)) begin errors++; $display("FAIL reset_priority: got busy %0b/%0b expected 0/0", busy, busy_s); end
        repeat (30) tick();
    endtask

    // Starts a window of g cycles (optional second start at cycle restart_at)
    // and checks done timing, single pulse and busy length.
    task automatic do_measurement(input int g, input int restart_at);
        int done_k = -1;
        int n_done = 0;
        int n_busy = 0;
        gate = 20'(g); start = 1'b1;
        for (int k = 1; k <= g + 10; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (restart_at != 0 && k == restart_at) start = 1'b1;
            if (restart_at != 0 && k == restart_at + 1) start = 1'b0;
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
        end
        checks++; if (done_k != g + 2) begin errors++; $display("FAIL done_cycle g=%0d: got %0d expected %0d", g, done_k, g + 2); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL done_pulses g=%0d: got %0d expected 1", g, n_done); end
        checks++; if (n_busy != g + 1) begin errors++; $display("FAIL busy_cycles g=%0d: got %0d expected %0d", g, n_busy, g + 1); end
    endtask

    task automatic read_results(input string tag);
        int unsigned e;
        for (int s = 0; s <= 4; s++) begin
            sel = 3'(s);
            tick();
            if (s < 4) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            end else begin
                e = 0;
            end
            checks++;
            if (count_out !== 16'(e)) begin
                errors++;
                $display("FAIL %s_sel%0d: got %0d expected %0d", tag, s, count_out, e);
            end
        end
        sel = 3'd0;
        tick();
    endtask

    task automatic test_basic();
        exp_q.push_back(10); exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(0);
        do_measurement(100, 0);
`ifdef RELAX_OSC_METER_OVERFLOW_EN
        checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL basic_ovf: got %b expected 0000", ovf); end
`endif
        read_results("basic");
    endtask

    task automatic test_zero_gate();
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        do_measurement(0, 0);
        read_results("zero");
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(10); exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(0);
        do_measurement(100, 30);
        read_results("b2b");
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        sel = 3'd0;
        gate = 20'd100; start = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == 50) rst = 1'b1;
            if (k == 51) begin
                rst = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
                checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", count_out); end
            end
            if (done === 1'b1) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", n_done); end
        test_basic();
    endtask

    task automatic test_saturate();
        int done_k = -1;
        int unsigned e;
        exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        gate_s = 20'd200; start_s = 1'b1;
        for (int k = 1; k <= 210; k++) begin
            tick();
            if (k == 1) start_s = 1'b0;
            if (done_s === 1'b1 && done_k < 0) done_k = k;
        end
        checks++; if (done_k != 202) begin errors++; $display("FAIL sat_done_cycle: got %0d expected 202", done_k); end
`ifdef RELAX_OSC_METER_OVERFLOW_EN
        checks++; if (ovf_s !== 4'b0001) begin errors++; $display("FAIL sat_ovf: got %b expected 0001", ovf_s); end
`endif
        for (int s = 0; s < 4; s++) begin
            sel_s = 3'(s);
            tick();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            checks++;
            if (count_out_s !== 4'(e)) begin
                errors++;
                $display("FAIL sat_sel%0d: got %0d expected %0d", s, count_out_s, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_gate();
        test_back_to_back();
        test_reset_abort();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relax_osc_meter.md
RELAX_OSC_METER -- requirements
Module: relax_osc_meter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of oscillator channels measured in parallel (legal range 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each channel's edge counter and result.
REQ-003 SHALL have parameter GATE_W, default 20, meaning the width of the gate-length input and the gate down-counter.
REQ-004 clk  input  1  sole clock; all state SHALL be updated on its rising edge only.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 osc_in  input  NUM_CH  asynchronous relaxation-oscillator outputs, one bit per channel.
REQ-007 gate_cycles  input  GATE_W  measurement window length in clk cycles, sampled on start.
REQ-008 start  input  1  single-cycle request to begin a measurement.
REQ-009 sel  input  $clog2(NUM_CH) (minimum 1)  channel whose result drives count_out.
REQ-010 busy  output  1  high while a measurement window is open.
REQ-011 done  output  1  one-cycle pulse when new results are latched.
REQ-012 count_out  output  CNT_W  latched edge count of channel sel.

Function
REQ-013 Each osc_in bit SHALL pass through a 2-flop synchroniser, then a rising-edge detector (current synced 1, previous synced 0).
REQ-014 The FSM SHALL have states IDLE, COUNT and LATCH.
- IDLE: start=1 -> COUNT next cycle; load gate counter from gate_cycles; clear all edge counters.
- COUNT: each cycle, decrement gate counter and add each channel's edge pulse to its counter; on the cycle gate counter equals 1 -> LATCH.
- LATCH: copy all edge counters to result registers; pulse done; -> IDLE.
REQ-015 The window SHALL span exactly gate_cycles clk cycles in COUNT; edges detected in IDLE or LATCH SHALL NOT be counted.
REQ-016 If gate_cycles=0 on start, the FSM SHALL go IDLE -> LATCH directly and latch all-zero results.
REQ-017 busy SHALL be 1 in COUNT and LATCH and 0 in IDLE.
REQ-018 start SHALL be ignored while busy=1; no restart and no queueing.
REQ-019 Edge counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 count_out SHALL be registered: it reflects the result register of sel one cycle after sel changes or after done.
REQ-021 If sel >= NUM_CH, count_out SHALL be 0.
REQ-022 Result registers SHALL hold their values until the next LATCH.
REQ-023 Input frequency requirement: osc_in frequency < clk/4; faster inputs give undefined counts and SHALL NOT corrupt the FSM.

Reset
REQ-024 rst=1 SHALL force the FSM to IDLE and clear synchronisers, edge counters, gate counter and result registers; busy=0, done=0, count_out=0 on the following cycle.
REQ-025 rst asserted mid-measurement SHALL abort it with no done pulse.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 With RELAX_OSC_METER_OVERFLOW_EN defined, the block SHALL add output ovf [NUM_CH]: a per-channel flag latched in LATCH, set if that channel saturated during the window, cleared by rst or by the next LATCH.
REQ-028 Without RELAX_OSC_METER_OVERFLOW_EN, the ovf port and its logic SHALL be absent; saturation per REQ-019 is unchanged.

Structure
REQ-029 Package relax_osc_pkg SHALL hold the FSM state enum (IDLE, COUNT, LATCH) and the default constants for NUM_CH, CNT_W and GATE_W.
REQ-030 The synchroniser and edge detector SHALL be one sub-module, relax_osc_edge_sync, instantiated once per channel.

Verification
REQ-031 gate_cycles=100; ch0 period 10 clk, ch1 period 25, ch2 and ch3 idle -> done at cycle 102 after start; counts 10/4/0/0 (+/-1 for phase).
REQ-032 gate_cycles=0 -> done pulse 2 cycles after start; all counts 0; busy high for exactly 1 cycle.
REQ-033 CNT_W=4; gate_cycles=200; ch0 period 8 -> count 15; ovf[0]=1 when the macro is defined.
REQ-034 Second start during COUNT -> ignored; a single done pulse; window length unchanged.
REQ-035 rst pulsed at cycle 50 of a 100-cycle window -> no done pulse; busy=0 and count_out=0 next cycle; a new start then succeeds.
REQ-036 Sweep sel 0..NUM_CH after a measurement -> each channel's result appears 1 cycle after its sel value; sel=NUM_CH (NUM_CH=4, sel 3 bits wide) -> 0.
